ti_link_packet_responder: RTL and testbench

- Packet-layer responder for the TI link, sitting on the byte side of dbus: consumes received bytes (dbus o_data/o_avail), parses TI link packets, streams the payload out, and verifies the checksum.
- Answers every data-bearing packet by queuing a 4-byte ACK (0x56) or checksum-error (0x5A) reply back into dbus (i_data/i_enable, gated by o_busy).
- Lets the design act as the device end of the link instead of a transparent UART bridge.

---
 rtl/ti_link_packet_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_ti_link_packet_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ti_link_packet_responder.sv
// TI link packet responder: parses received link packets, streams the payload,
// verifies the checksum and queues a 4-byte ACK or checksum-error reply.
module ti_link_packet_responder #(
    parameter int unsigned c_TIMEOUT = 20000,
    parameter logic [7:0]  c_MID     = 8'h23
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [7:0]  i_rxdata,
    input  logic        i_rxavail,
    output logic        o_rxread,
    output logic [7:0]  o_txdata,
    output logic        o_txenable,
    input  logic        i_txbusy,
    output logic [7:0]  o_cid,
    output logic [15:0] o_len,
    output logic [7:0]  o_payload,
    output logic        o_payload_valid,
    output logic        o_pkt_ok,
    output logic        o_pkt_err,
    output logic        o_timeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_CID, S_LENL, S_LENH, S_DATA,
        S_CSL, S_CSH, S_DONE, S_REPLY
    } state_t;

    localparam int TW = $clog2(c_TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(c_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          rxread_q, rxread_d;
    logic [7:0]    cid_q, cid_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   sum_q, sum_d;
    logic [7:0]    csl_q, csl_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    pay_q, pay_d;
    logic          payv_q, payv_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic          to_q, to_d;
    logic [7:0]    rcid_q, rcid_d;
    logic [1:0]    tidx_q, tidx_d;
    logic [7:0]    txd_q, txd_d;
    logic          txen_q, txen_d;

    logic       take;
    logic       data_cid;
    logic [7:0] reply_byte;

    assign data_cid = (cid_q == 8'h06) || (cid_q == 8'h15) ||
                      (cid_q == 8'h36) || (cid_q == 8'h88) ||
                      (cid_q == 8'hA2) || (cid_q == 8'hC9);

    // A byte is consumed only when the parser can act on it this cycle.
    assign take = i_rxavail && !rxread_q &&
                  (state_q != S_DONE) && (state_q != S_REPLY);

    always_comb begin
        unique case (tidx_q)
            2'd0:    reply_byte = c_MID;
            2'd1:    reply_byte = rcid_q;
            default: reply_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rxread_d = rxread_q;
        cid_d    = cid_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        csl_d    = csl_q;
        tcnt_d   = tcnt_q;
        pay_d    = pay_q;
        payv_d   = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        rcid_d   = rcid_q;
        tidx_d   = tidx_q;
        txd_d    = txd_q;
        txen_d   = txen_q;

        if (rxread_q && !i_rxavail)
            rxread_d = 1'b0;
        if (take)
            rxread_d = 1'b1;

        unique case (state_q)
            S_IDLE: if (take) begin
                sum_d   = '0;
                cnt_d   = '0;
                state_d = S_CID;
            end
            S_CID: if (take) begin
                cid_d   = i_rxdata;
                state_d = S_LENL;
            end
            S_LENL: if (take) begin
                len_d[7:0] = i_rxdata;
                state_d    = S_LENH;
            end
            S_LENH: if (take) begin
                len_d[15:8] = i_rxdata;
                if (!data_cid)
                    state_d = S_DONE;
                else if ({i_rxdata, len_q[7:0]} != 16'd0)
                    state_d = S_DATA;
                else
                    state_d = S_CSL;
            end
            S_DATA: if (take) begin
                pay_d  = i_rxdata;
                payv_d = 1'b1;
                sum_d  = sum_q + {8'h00, i_rxdata};
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q == len_q - 16'd1)
                    state_d = S_CSL;
            end
            S_CSL: if (take) begin
                csl_d   = i_rxdata;
                state_d = S_CSH;
            end
            S_CSH: if (take) begin
                if ({i_rxdata, csl_q} == sum_q) begin
                    ok_d   = 1'b1;
                    rcid_d = 8'h56;
                end else begin
                    err_d  = 1'b1;
                    rcid_d = 8'h5A;
                end
                tidx_d  = 2'd0;
                state_d = S_REPLY;
            end
            S_DONE: state_d = S_IDLE;
            S_REPLY: begin
                if (txen_q) begin
                    if (i_txbusy) begin
                        txen_d = 1'b0;
                        if (tidx_q == 2'd3)
                            state_d = S_IDLE;
                        else
                            tidx_d = tidx_q + 2'd1;
                    end
                end else if (!i_txbusy) begin
                    txen_d = 1'b1;
                    txd_d  = reply_byte;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            tcnt_d = '0;
        end else if (state_q == S_IDLE || state_q == S_REPLY ||
                     state_q == S_DONE) begin
            tcnt_d = '0;
        end else if (tcnt_q >= TLAST) begin
            to_d    = 1'b1;
            sum_d   = '0;
            tcnt_d  = '0;
            state_d = S_IDLE;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            rxread_q <= 1'b0;
            cid_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            csl_q    <= '0;
            tcnt_q   <= '0;
            pay_q    <= '0;
            payv_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            rcid_q   <= '0;
            tidx_q   <= '0;
            txd_q    <= '0;
            txen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rxread_q <= rxread_d;
            cid_q    <= cid_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            csl_q    <= csl_d;
            tcnt_q   <= tcnt_d;
            pay_q    <= pay_d;
            payv_q   <= payv_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            to_q     <= to_d;
            rcid_q   <= rcid_d;
            tidx_q   <= tidx_d;
            txd_q    <= txd_d;
            txen_q   <= txen_d;
        end
    end

    assign o_rxread        = rxread_q;
    assign o_txdata        = txd_q;
    assign o_txenable      = txen_q;
    assign o_cid           = cid_q;
    assign o_len           = len_q;
    assign o_payload       = pay_q;
    assign o_payload_valid = payv_q;
    assign o_pkt_ok        = ok_q;
    assign o_pkt_err       = err_q;
    assign o_timeout       = to_q;

endmodule

// File: tb/tb_ti_link_packet_responder.sv
// Directed bench for ti_link_packet_responder with a small dbus model
// on both the receive and transmit sides.
module tb_ti_link_packet_responder;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rxdata = 8'h00;
    logic        rxavail = 1'b0;
    logic        o_rxread;
    logic [7:0]  o_txdata;
    logic        o_txenable;
    logic        busy_gen = 1'b0;
    logic        hold_busy = 1'b0;
    logic        txbusy;
    logic [7:0]  o_cid;
    logic [15:0] o_len;
    logic [7:0]  o_payload;
    logic        o_payload_valid;
    logic        o_pkt_ok;
    logic        o_pkt_err;
    logic        o_timeout;

    assign txbusy = busy_gen | hold_busy;

    ti_link_packet_responder #(.c_TIMEOUT(TO), .c_MID(8'h23)) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_rxdata(rxdata),
        .i_rxavail(rxavail),
        .o_rxread(o_rxread),
        .o_txdata(o_txdata),
        .o_txenable(o_txenable),
        .i_txbusy(txbusy),
        .o_cid(o_cid),
        .o_len(o_len),
        .o_payload(o_payload),
        .o_payload_valid(o_payload_valid),
        .o_pkt_ok(o_pkt_ok),
        .o_pkt_err(o_pkt_err),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int nok = 0;
    int nerr = 0;
    int nto = 0;
    int nrd_hold = 0;
    logic [7:0] payq[$];
    logic [7:0] txq[$];
    logic [7:0] pkt[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (o_payload_valid) payq.push_back(o_payload);
        if (o_pkt_ok) nok++;
        if (o_pkt_err) nerr++;
        if (o_timeout) nto++;
        if (hold_busy && o_rxread) nrd_hold++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (o_txenable && !txbusy) begin
            txq.push_back(o_txdata);
            busy_gen = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            busy_gen = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        payq.delete();
        txq.delete();
        nok = 0;
        nerr = 0;
        nto = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        rxdata = b;
        rxavail = 1'b1;
        n = 0;
        while (!o_rxread && n < 3000) begin
            cyc(1);
            n++;
        end
        if (!o_rxread) check("rxread_hi", {31'd0, o_rxread}, 32'd1);
        rxavail = 1'b0;
        n = 0;
        while (o_rxread && n < 20) begin
            cyc(1);
            n++;
        end
        if (o_rxread) check("rxread_lo", {31'd0, o_rxread}, 32'd0);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while (txq.size() < n && k < 3000) begin
            cyc(1);
            k++;
        end
        if (txq.size() < n) check("tx_wait", txq.size(), n);
    endtask

    function automatic logic [31:0] tx32();
        if (txq.size() != 4) return 32'hDEADBEEF;
        return {txq[0], txq[1], txq[2], txq[3]};
    endfunction

    task automatic check_rst(input string tag);
        check({tag, "_ctl"},
              {2'b00, o_rxread, o_txenable, o_payload_valid, o_pkt_ok,
               o_pkt_err, o_timeout, o_cid, o_len}, 32'd0);
        check({tag, "_dat"}, {16'd0, o_txdata, o_payload}, 32'd0);
    endtask

    initial begin
        cyc(3);
        check_rst("reset");
        rst_n = 1'b1;
        cyc(3);

        // good packet
        clr();
        pkt = {8'h23, 8'h15, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h00};
        send_pkt();
        wait_tx(4);
        cyc(20);
        check("ok_pay_n", payq.size(), 3);
        if (payq.size() == 3)
            check("ok_pay", {8'h00, payq[0], payq[1], payq[2]}, 32'h00010203);
        check("ok_cnt", {nok[15:0], nerr[15:0]}, 32'h0001_0000);
        check("ok_len", {16'd0, o_len}, 32'd3);
        check("ok_cid", {24'd0, o_cid}, 32'h15);
        check("ok_reply", tx32(), 32'h23560000);

        // bad checksum
        clr();
        pkt = {8'h23, 8'h15, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h00};
        send_pkt();
        wait_tx(4);
        cyc(20);
        check("err_cnt", {nok[15:0], nerr[15:0]}, 32'h0000_0001);
        check("err_reply", tx32(), 32'h235A0000);

        // non data-bearing CID
        clr();
        pkt = {8'h73, 8'h68, 8'h00, 8'h00};
        send_pkt();
        cyc(30);
        check("nd_pulses", {payq.size(), 8'd0} + nok + nerr + nto, 32'd0);
        check("nd_tx", txq.size(), 0);
        check("nd_cid", {24'd0, o_cid}, 32'h68);
        pkt = {8'h23, 8'h15, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h00};
        send_pkt();
        wait_tx(4);
        cyc(10);
        check("nd_next_ok", nok, 1);

        // zero-length data packet
        clr();
        pkt = {8'h23, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx(4);
        cyc(10);
        check("z_cnt", {nok[15:0], nerr[15:0]}, 32'h0001_0000);
        check("z_pay", payq.size(), 0);
        check("z_reply", tx32(), 32'h23560000);

        // inter-byte timeout
        clr();
        pkt = {8'h23, 8'h15, 8'h02, 8'h00, 8'hFF};
        send_pkt();
        cyc(TO + 20);
        check("to_pulse", nto, 1);
        check("to_tx", txq.size(), 0);
        check("to_ok", nok + nerr, 0);
        clr();
        pkt = {8'h23, 8'h15, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h00};
        send_pkt();
        wait_tx(4);
        cyc(10);
        check("to_next_ok", {nok[15:0], nerr[15:0]}, 32'h0001_0000);
        check("to_next_reply", tx32(), 32'h23560000);

        // 300 x FF, checksum wraps to 0x2AD4, long busy stall
        clr();
        pkt = {8'h23, 8'h15, 8'h2C, 8'h01};
        for (int i = 0; i < 300; i++) pkt.push_back(8'hFF);
        pkt.push_back(8'hD4);
        pkt.push_back(8'h2A);
        send_pkt();
        wait_tx(1);
        hold_busy = 1'b1;
        rxdata = 8'h23;
        rxavail = 1'b1;
        nrd_hold = 0;
        cyc(500);
        check("hold_rd", nrd_hold, 0);
        check("hold_tx", txq.size(), 1);
        hold_busy = 1'b0;
        wait_tx(4);
        cyc(20);
        check("wrap_pay_n", payq.size(), 300);
        begin
            int nff;
            nff = 0;
            foreach (payq[i]) if (payq[i] != 8'hFF) nff++;
            check("wrap_pay_ff", nff, 0);
        end
        check("wrap_ok", {nok[15:0], nerr[15:0]}, 32'h0001_0000);
        check("wrap_len", {16'd0, o_len}, 32'd300);
        check("wrap_reply", tx32(), 32'h23560000);
        clr();
        send_byte(8'h23);
        pkt = {8'h15, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx(4);
        cyc(10);
        check("after_hold_ok", nok, 1);
        check("after_hold_reply", tx32(), 32'h23560000);

        // reset during DATA
        clr();
        pkt = {8'h23, 8'h15, 8'h03, 8'h00, 8'h01};
        send_pkt();
        cyc(2);
        rst_n = 1'b0;
        #1;
        check_rst("rst_data");
        cyc(2);
        rst_n = 1'b1;
        cyc(TO + 20);
        check("rst_data_quiet", txq.size() + nok + nerr + nto, 0);

        // reset during reply
        clr();
        pkt = {8'h23, 8'h15, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h00};
        send_pkt();
        wait_tx(1);
        hold_busy = 1'b1;
        cyc(5);
        rst_n = 1'b0;
        #1;
        check_rst("rst_reply");
        cyc(2);
        rst_n = 1'b1;
        hold_busy = 1'b0;
        cyc(50);
        check("rst_reply_tx", txq.size(), 1);

        clr();
        send_pkt();
        wait_tx(4);
        cyc(10);
        check("rst_next_ok", {nok[15:0], nerr[15:0]}, 32'h0001_0000);
        check("rst_next_reply", tx32(), 32'h23560000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
